// File: rtl/npc_if.sv
// Fetch-side lookup and resolve-side training bus of the next-PC predictor.
interface npc_if;
  logic [29:0] if_pc;
  logic        hit;
  logic        pred_taken;
  logic [29:0] pred_target;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_call;
  logic        flush;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_call, flush,
    input  hit, pred_taken, pred_target
  );
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_call, flush,
    output hit, pred_taken, pred_target
  );
endinterface

// File: rtl/npc_predictor.sv
// Direct-mapped BTB with 2-bit counters plus a circular return-address stack.
// Lookup is combinational from state; training lands on the next edge.
module npc_predictor #(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  npc_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] K_BR  = 2'b00;
  localparam logic [1:0] K_RET = 2'b10;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][1:0]        kind;
  logic [ENTRIES-1:0][1:0]        ctr;
  logic [ENTRIES-1:0][29:0]       tgt;

  logic [RAS_DEPTH-1:0][29:0]     ras;
  logic [PTR_W-1:0]               top_ptr;
  logic [PTR_W:0]                 count;

  // lookup
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic             l_taken;

  assign l_idx = bus.if_pc[IDX_W-1:0];
  assign l_tag = bus.if_pc[IDX_W+TAG_W-1:IDX_W];
  assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);

  always_comb begin
    l_taken = 1'b0;
    if (l_hit) begin
      case (kind[l_idx])
        K_BR:    l_taken = ctr[l_idx][1];
        K_RET:   l_taken = (count != '0);
        default: l_taken = 1'b1;
      endcase
    end
  end

  assign bus.hit         = l_hit;
  assign bus.pred_taken  = l_taken;
  assign bus.pred_target = !l_taken              ? 30'd0 :
                           (kind[l_idx] == K_RET) ? ras[top_ptr] : tgt[l_idx];

  // training
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             go;
  logic             is_br;
  logic             wr_meta;
  logic             wr_tgt;

  assign u_idx   = bus.upd_pc[IDX_W-1:0];
  assign u_tag   = bus.upd_pc[IDX_W+TAG_W-1:IDX_W];
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign go      = bus.upd_valid && !bus.flush;
  assign is_br   = (bus.upd_kind == K_BR);
  assign wr_tgt  = go && (!is_br || bus.upd_taken);
  assign wr_meta = wr_tgt || (go && u_hit);

  generate
    if (IDX_W + TAG_W < 30) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{bus.if_pc[29:IDX_W+TAG_W], bus.upd_pc[29:IDX_W+TAG_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      ctr   <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else if (bus.upd_valid) begin
      if (is_br) begin
        if (u_hit) begin
          if (bus.upd_taken) ctr[u_idx] <= (ctr[u_idx] == 2'b11) ? 2'b11 : ctr[u_idx] + 2'b01;
          else               ctr[u_idx] <= (ctr[u_idx] == 2'b00) ? 2'b00 : ctr[u_idx] - 2'b01;
        end else if (bus.upd_taken) begin
          valid[u_idx] <= 1'b1;
          ctr[u_idx]   <= 2'b10;
        end
      end else begin
        valid[u_idx] <= 1'b1;
        ctr[u_idx]   <= 2'b11;
      end
    end
  end

  // tag/kind/target need no reset: valid gates every use of them
  always_ff @(posedge clk) begin
    if (wr_meta) begin
      tag[u_idx]  <= u_tag;
      kind[u_idx] <= bus.upd_kind;
    end
    if (wr_tgt) tgt[u_idx] <= bus.upd_target;
  end

  // return-address stack
  logic             push;
  logic             pop;
  logic [29:0]      ret_addr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  assign push     = go && bus.upd_call;
  assign pop      = go && (bus.upd_kind == K_RET);
  assign ret_addr = bus.upd_pc + 30'd2;
  assign ptr_inc  = top_ptr + PTR_W'(1);
  assign ptr_dec  = top_ptr - PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (bus.flush) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push && !pop) begin
      // when full the slot past top is the oldest entry, so it is simply overwritten
      top_ptr <= ptr_inc;
      if (count != (PTR_W+1)'(RAS_DEPTH)) count <= count + (PTR_W+1)'(1);
    end else if (pop && !push && count != '0) begin
      top_ptr <= ptr_dec;
      count   <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && pop)  ras[top_ptr] <= ret_addr;
    else if (push)    ras[ptr_inc] <= ret_addr;
  end
endmodule

// File: tb/tb_npc_predictor.sv
// Directed bench for npc_predictor: counter training, aliasing, RAS, flush, async reset.
module tb_npc_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  npc_if bus ();

  npc_predictor #(.ENTRIES(16), .TAG_W(8), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [29:0] obs, input logic [29:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic look(input string name, input logic [29:0] pc,
                      input logic h, input logic t, input logic [29:0] tg);
    bus.if_pc = pc;
    #1;
    chk({name, ".hit"},    30'(bus.hit),        30'(h));
    chk({name, ".taken"},  30'(bus.pred_taken), 30'(t));
    chk({name, ".target"}, bus.pred_target,     tg);
  endtask

  task automatic upd(input logic [29:0] pc, input logic [1:0] k, input logic tk,
                     input logic [29:0] tg, input logic call, input logic fl);
    @(negedge clk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_kind   = k;
    bus.upd_taken  = tk;
    bus.upd_target = tg;
    bus.upd_call   = call;
    bus.flush      = fl;
    @(posedge clk);
    #1;
    bus.upd_valid  = 1'b0;
    bus.upd_call   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    bus.if_pc = 30'h400; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_kind = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_call = 0; bus.flush = 0;
    #2;
    look("reset", 30'h400, 0, 0, 30'h0);
    @(negedge clk); rst_n = 1'b1;

    // counter training at idx 0
    upd(30'h100, 2'b00, 1, 30'h200, 0, 0);          // allocate ctr=10
    look("br_alloc", 30'h100, 1, 1, 30'h200);
    upd(30'h100, 2'b00, 0, 30'h0, 0, 0);            // 01
    upd(30'h100, 2'b00, 0, 30'h0, 0, 0);            // 00
    look("br_nt2", 30'h100, 1, 0, 30'h0);
    upd(30'h100, 2'b00, 0, 30'h0, 0, 0);            // stays 00
    look("br_sat_lo", 30'h100, 1, 0, 30'h0);
    upd(30'h100, 2'b00, 1, 30'h200, 0, 0);          // 01
    look("br_t1", 30'h100, 1, 0, 30'h0);
    upd(30'h100, 2'b00, 1, 30'h200, 0, 0);          // 10
    look("br_t2", 30'h100, 1, 1, 30'h200);
    upd(30'h100, 2'b00, 1, 30'h240, 0, 0);          // 11, new target
    upd(30'h100, 2'b00, 1, 30'h240, 0, 0);          // stays 11
    upd(30'h100, 2'b00, 0, 30'h0, 0, 0);            // 10
    look("br_sat_hi", 30'h100, 1, 1, 30'h240);

    // aliasing: 0x100 and 0x110 share idx 0
    upd(30'h100, 2'b01, 1, 30'h300, 0, 0);
    look("j_100", 30'h100, 1, 1, 30'h300);
    upd(30'h110, 2'b01, 1, 30'h500, 0, 0);
    look("alias_old", 30'h100, 0, 0, 30'h0);
    look("alias_new", 30'h110, 1, 1, 30'h500);
    upd(30'h120, 2'b00, 0, 30'h0, 0, 0);            // miss, not taken: no change
    look("nt_miss", 30'h120, 0, 0, 30'h0);
    look("nt_keep", 30'h110, 1, 1, 30'h500);

    // RAS: return entry at idx 1 so calls at idx 0 leave it alone
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);            // pop on empty
    look("ret_empty", 30'h091, 1, 0, 30'h0);
    upd(30'h040, 2'b01, 1, 30'h1000, 1, 0);
    upd(30'h050, 2'b01, 1, 30'h1000, 1, 0);
    upd(30'h060, 2'b01, 1, 30'h1000, 1, 0);
    upd(30'h070, 2'b01, 1, 30'h1000, 1, 0);
    upd(30'h080, 2'b01, 1, 30'h1000, 1, 0);         // overwrites 0x42
    look("ras_top", 30'h091, 1, 1, 30'h082);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);
    look("ras_pop1", 30'h091, 1, 1, 30'h072);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);
    look("ras_pop2", 30'h091, 1, 1, 30'h062);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);
    look("ras_pop3", 30'h091, 1, 1, 30'h052);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);
    look("ras_under", 30'h091, 1, 0, 30'h0);
    look("call_j", 30'h080, 1, 1, 30'h1000);
    upd(30'h040, 2'b01, 1, 30'h1000, 1, 0);         // count 1, top 0x42
    upd(30'h091, 2'b10, 1, 30'h0, 1, 0);            // push+pop: top = 0x93
    look("ras_pp", 30'h091, 1, 1, 30'h093);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);
    look("ras_pp_cnt", 30'h091, 1, 0, 30'h0);

    // flush beats a simultaneous update
    upd(30'h040, 2'b01, 1, 30'h1000, 1, 0);
    upd(30'h040, 2'b01, 1, 30'h1000, 1, 0);         // count 2
    upd(30'h102, 2'b01, 1, 30'h700, 0, 0);
    look("pre_flush", 30'h102, 1, 1, 30'h700);
    upd(30'h103, 2'b01, 1, 30'h800, 1, 1);
    look("fl_102", 30'h102, 0, 0, 30'h0);
    look("fl_091", 30'h091, 0, 0, 30'h0);
    look("fl_040", 30'h040, 0, 0, 30'h0);
    look("fl_drop", 30'h103, 0, 0, 30'h0);
    upd(30'h091, 2'b10, 1, 30'h0, 0, 0);            // empty RAS: pop is a no-op
    look("fl_ras", 30'h091, 1, 0, 30'h0);

    // asynchronous reset mid-cycle
    upd(30'h104, 2'b01, 1, 30'h900, 0, 0);
    look("pre_rst", 30'h104, 1, 1, 30'h900);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.hit",    30'(bus.hit),        30'h0);
    chk("arst.taken",  30'(bus.pred_taken), 30'h0);
    chk("arst.target", bus.pred_target,     30'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
